// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// Optional round-robin arbitration is enabled with MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MEM_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IFU,
        GNT_LSU
    } grant_t;

endpackage

// File: rtl/mem_arbiter_arb2.sv
// Two-input arbiter: fixed LSU priority by default, round-robin when
// MEM_ARB_RR_EN is defined (adds a last-grant flop and its clock/reset).
module arb2
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic   clk,
    input  logic   rst,
    input  logic   i_update,
`endif
    input  logic   i_req_ifu,
    input  logic   i_req_lsu,
    output grant_t o_gnt
);

`ifdef MEM_ARB_RR_EN
    // 1 = LSU was granted last; resets to IFU so the first tie goes to LSU
    logic r_last_lsu;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_lsu <= 1'b0;
        end else if (i_update && (o_gnt != GNT_NONE)) begin
            r_last_lsu <= (o_gnt == GNT_LSU);
        end
    end

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_req_ifu && i_req_lsu) begin
            o_gnt = r_last_lsu ? GNT_IFU : GNT_LSU;
        end else if (i_req_lsu) begin
            o_gnt = GNT_LSU;
        end else if (i_req_ifu) begin
            o_gnt = GNT_IFU;
        end
    end
`else
    always_comb begin
        o_gnt = GNT_NONE;
        if (i_req_lsu) begin
            o_gnt = GNT_LSU;
        end else if (i_req_ifu) begin
            o_gnt = GNT_IFU;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialising IFU/LSU arbiter for the 256x32 memory with programmable latency.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [XLEN-1:0] ifu_req_addr,
    output logic            ifu_resp_valid,
    input  logic            ifu_resp_ready,
    output logic [XLEN-1:0] ifu_resp_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic            lsu_req_wen,
    input  logic [XLEN-1:0] lsu_req_addr,
    input  logic [XLEN-1:0] lsu_req_wdata,
    output logic            lsu_resp_valid,
    input  logic            lsu_resp_ready,
    output logic [XLEN-1:0] lsu_resp_rdata,
    output logic            mem_wen,
    output logic            mem_ren,
    output logic [XLEN-1:0] mem_waddr,
    output logic [XLEN-1:0] mem_raddr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    grant_t           r_gnt;
    grant_t           w_arb_gnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wen;
    logic [XLEN-1:0]  r_addr;
    logic [XLEN-1:0]  r_wdata;
    logic [XLEN-1:0]  r_rdata;
    logic [XLEN-1:0]  r_mem_waddr;
    logic [XLEN-1:0]  r_mem_raddr;
    logic [XLEN-1:0]  r_mem_wdata;
    logic             w_accept;
    logic             w_resp_done;

    arb2 u_arb2 (
`ifdef MEM_ARB_RR_EN
        .clk       (clk),
        .rst       (rst),
        .i_update  (r_state == IDLE),
`endif
        .i_req_ifu (ifu_req_valid),
        .i_req_lsu (lsu_req_valid),
        .o_gnt     (w_arb_gnt)
    );

    assign ifu_resp_rdata = r_rdata;
    assign lsu_resp_rdata = r_rdata;

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_resp_done    = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        mem_wen        = 1'b0;
        mem_ren        = 1'b0;
        mem_waddr      = r_mem_waddr;
        mem_raddr      = r_mem_raddr;
        mem_wdata      = r_mem_wdata;
        case (r_state)
            IDLE: begin
                ifu_req_ready = (w_arb_gnt == GNT_IFU);
                lsu_req_ready = (w_arb_gnt == GNT_LSU);
                if (w_arb_gnt != GNT_NONE) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (LATENCY > 1) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // pins are live only here; the hold registers replay them afterwards
                if (r_wen) begin
                    mem_wen   = 1'b1;
                    mem_waddr = r_addr;
                    mem_wdata = r_wdata;
                end else begin
                    mem_ren   = 1'b1;
                    mem_raddr = r_addr;
                end
                w_state_nxt = RESP;
            end
            RESP: begin
                ifu_resp_valid = (r_gnt == GNT_IFU);
                lsu_resp_valid = (r_gnt == GNT_LSU);
                w_resp_done    = (ifu_resp_valid && ifu_resp_ready) ||
                                 (lsu_resp_valid && lsu_resp_ready);
                if (w_resp_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= GNT_NONE;
            r_cnt       <= '0;
            r_wen       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mem_waddr <= '0;
            r_mem_raddr <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_gnt <= w_arb_gnt;
                        r_cnt <= CNT_W'(LATENCY - 1);
                        if (w_arb_gnt == GNT_LSU) begin
                            r_wen   <= lsu_req_wen;
                            r_addr  <= lsu_req_addr;
                            r_wdata <= lsu_req_wdata;
                        end else begin
                            r_wen   <= 1'b0;
                            r_addr  <= ifu_req_addr;
                            r_wdata <= '0;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ACCESS: begin
                    r_rdata <= r_wen ? '0 : mem_rdata;
                    if (r_wen) begin
                        r_mem_waddr <= r_addr;
                        r_mem_wdata <= r_wdata;
                    end else begin
                        r_mem_raddr <= r_addr;
                    end
                end
                RESP: begin
                    if (w_resp_done) begin
                        r_gnt <= GNT_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a transaction-level timing model.
// Build with MEM_ARB_RR_EN to check round-robin arbitration.
module tb_mem_arbiter;

    localparam int unsigned LAT  = 3;
    localparam int unsigned NCYC = 3000;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_req_addr, ifu_resp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_waddr, mem_raddr, mem_wdata, mem_rdata;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    mem_arbiter #(.LATENCY(LAT), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .ifu_resp_rdata (ifu_resp_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_resp_rdata (lsu_resp_rdata),
        .mem_wen        (mem_wen),
        .mem_ren        (mem_ren),
        .mem_waddr      (mem_waddr),
        .mem_raddr      (mem_raddr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] init_val(input logic [7:0] idx);
        if (idx == 8'd0) return '0;
        if (idx == 8'd4) return 32'hDEADBEEF;
        return {idx, ~idx, 8'h5A, idx ^ 8'hC3};
    endfunction

    // Memory environment: unwritten words read back their initial pattern
    logic        mem_clr;
    logic [31:0] mem_data [256];
    logic        mem_wr   [256];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_wr[i] <= 1'b0;
        end else if (mem_wen && (mem_waddr[7:0] != 8'd0)) begin
            mem_data[mem_waddr[7:0]] <= mem_wdata;
            mem_wr[mem_waddr[7:0]]   <= 1'b1;
        end
    end

    assign mem_rdata = mem_ren ? (mem_wr[mem_raddr[7:0]] ? mem_data[mem_raddr[7:0]]
                                                          : init_val(mem_raddr[7:0])) : '0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a      = $urandom();
        a[7:0] = 8'($urandom_range(0, 7) * 4);
        return a;
    endfunction

    // Reference model state
    logic [31:0] ref_mem [256];
    logic        busy, own_lsu, t_wr, last_lsu;
    int unsigned t_acc, n_done, bp_left;
    logic [31:0] t_addr, t_wdata, exp_rdata;
    logic        ifu_pend, lsu_pend;
    logic        tie_ifu, exp_ifu_rdy, exp_lsu_rdy, acc, rsp;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        mem_clr        = 1'b1;
        rst            = 1'b1;
        ifu_req_valid  = 1'b0; ifu_req_addr  = '0; ifu_resp_ready = 1'b0;
        lsu_req_valid  = 1'b0; lsu_req_wen   = 1'b0;
        lsu_req_addr   = '0;   lsu_req_wdata = '0; lsu_resp_ready = 1'b0;
        busy = 1'b0; own_lsu = 1'b0; t_wr = 1'b0; last_lsu = 1'b0;
        t_acc = 0; n_done = 0; bp_left = 0;
        t_addr = '0; t_wdata = '0; exp_rdata = '0;
        ifu_pend = 1'b0; lsu_pend = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        chk_eq("rst_ifu_req_ready",  32'(ifu_req_ready),  '0);
        chk_eq("rst_lsu_req_ready",  32'(lsu_req_ready),  '0);
        chk_eq("rst_ifu_resp_valid", 32'(ifu_resp_valid), '0);
        chk_eq("rst_lsu_resp_valid", 32'(lsu_resp_valid), '0);
        chk_eq("rst_mem_wen",        32'(mem_wen),        '0);
        chk_eq("rst_mem_ren",        32'(mem_ren),        '0);
        chk_eq("rst_mem_waddr",      mem_waddr,           '0);
        chk_eq("rst_mem_raddr",      mem_raddr,           '0);
        chk_eq("rst_mem_wdata",      mem_wdata,           '0);
        chk_eq("rst_ifu_resp_rdata", ifu_resp_rdata,      '0);
        chk_eq("rst_lsu_resp_rdata", lsu_resp_rdata,      '0);
        @(posedge clk);
        #1;

        for (int n = 0; n < int'(NCYC); n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!ifu_pend && ($urandom_range(0, 2) == 0)) begin
                ifu_pend     = 1'b1;
                ifu_req_addr = rand_addr();
            end
            if (!lsu_pend && ($urandom_range(0, 2) == 0)) begin
                lsu_pend      = 1'b1;
                lsu_req_wen   = 1'($urandom_range(0, 1));
                lsu_req_addr  = rand_addr();
                lsu_req_wdata = $urandom();
            end
            ifu_req_valid = ifu_pend;
            lsu_req_valid = lsu_pend;
            if (bp_left > 0) begin
                ifu_resp_ready = 1'b0;
                bp_left--;
            end else begin
                if ($urandom_range(0, 39) == 0) bp_left = 5;
                ifu_resp_ready = ($urandom_range(0, 3) != 0);
            end
            lsu_resp_ready = 1'($urandom_range(0, 1));

            @(negedge clk);
            tie_ifu = 1'b0;
`ifdef MEM_ARB_RR_EN
            tie_ifu = last_lsu;
`endif
            exp_lsu_rdy = !busy && lsu_req_valid && !(ifu_req_valid && tie_ifu);
            exp_ifu_rdy = !busy && ifu_req_valid && (!lsu_req_valid || tie_ifu);
            acc = busy && (cyc == t_acc);
            rsp = busy && (cyc > t_acc);

            chk_eq("ifu_req_ready",  32'(ifu_req_ready),  32'(exp_ifu_rdy));
            chk_eq("lsu_req_ready",  32'(lsu_req_ready),  32'(exp_lsu_rdy));
            chk_eq("mem_wen",        32'(mem_wen),        32'(acc && t_wr));
            chk_eq("mem_ren",        32'(mem_ren),        32'(acc && !t_wr));
            chk_eq("ifu_resp_valid", 32'(ifu_resp_valid), 32'(rsp && !own_lsu));
            chk_eq("lsu_resp_valid", 32'(lsu_resp_valid), 32'(rsp && own_lsu));
            if (acc && t_wr) begin
                chk_eq("mem_waddr", mem_waddr, t_addr);
                chk_eq("mem_wdata", mem_wdata, t_wdata);
            end
            if (acc && !t_wr) chk_eq("mem_raddr", mem_raddr, t_addr);
            if (rsp && own_lsu)  chk_eq("lsu_resp_rdata", lsu_resp_rdata, exp_rdata);
            if (rsp && !own_lsu) chk_eq("ifu_resp_rdata", ifu_resp_rdata, exp_rdata);

            if (acc) begin
                if (t_wr) begin
                    if (t_addr[7:0] != 8'd0) ref_mem[t_addr[7:0]] = t_wdata;
                    exp_rdata = '0;
                end else begin
                    exp_rdata = ref_mem[t_addr[7:0]];
                end
            end
            if (rsp && (own_lsu ? lsu_resp_ready : ifu_resp_ready)) begin
                busy = 1'b0;
                n_done++;
            end
            if (exp_ifu_rdy || exp_lsu_rdy) begin
                busy     = 1'b1;
                own_lsu  = exp_lsu_rdy;
                last_lsu = exp_lsu_rdy;
                t_acc    = cyc + LAT;
                t_wr     = exp_lsu_rdy && lsu_req_wen;
                t_addr   = exp_lsu_rdy ? lsu_req_addr : ifu_req_addr;
                t_wdata  = lsu_req_wdata;
                if (exp_lsu_rdy) lsu_pend = 1'b0;
                else             ifu_pend = 1'b0;
            end
            // a sampled reset aborts everything, including requests not yet accepted
            if (rst) begin
                busy     = 1'b0;
                last_lsu = 1'b0;
                ifu_pend = 1'b0;
                lsu_pend = 1'b0;
            end
            cyc++;
            @(posedge clk);
            #1;
        end

        rst           = 1'b0;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        begin
            int unsigned diffs;
            diffs = 0;
            for (int i = 0; i < 256; i++) begin
                if ((mem_wr[i] ? mem_data[i] : init_val(8'(i))) !== ref_mem[i]) diffs++;
            end
            chk_eq("mem_image_diffs", diffs, 0);
        end
        chk_eq("progress_ge_100", 32'(n_done >= 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 256x32 data/instruction memory of the multicycle core.
- Requesters: IFU (read-only) and LSU (read/write). Both use a valid/ready request channel and a valid/ready response channel.
- Serializes accesses and models a programmable access latency.
- Drives the memory's wen/ren/waddr/raddr/wdata pins and samples its combinational rdata.

Parameters:
- LATENCY, 1: cycles from request acceptance to the memory access cycle; must be >=1.
- CNT_W, 4: width of the latency counter; requires LATENCY < 2**CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  32  IFU address
- ifu_resp_valid  out  1  IFU response available
- ifu_resp_ready  in  1  IFU consumes response
- ifu_resp_rdata  out  32  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_addr  in  32  LSU address
- lsu_req_wdata  in  32  LSU write data
- lsu_resp_valid  out  1  LSU response available
- lsu_resp_ready  in  1  LSU consumes response
- lsu_resp_rdata  out  32  LSU read data; 0 for writes
- mem_wen  out  1  memory write enable
- mem_ren  out  1  memory read enable
- mem_waddr  out  32  memory write address
- mem_raddr  out  32  memory read address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_raddr/mem_ren

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - FSM = IDLE, counter = 0, grant = none.
  - All *_ready, *_resp_valid, mem_wen and mem_ren are 0.
  - Response data, captured address and captured data registers are 0.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If any req_valid is high, pick a winner and assert that requester's req_ready combinationally in the same cycle. The loser's ready stays 0.
  - On the handshake, capture addr, wen (IFU is forced to 0) and wdata, and record the grant.
  - Next state is WAIT if LATENCY>1, else ACCESS. The counter loads LATENCY-1.
- WAIT: counter decrements each cycle; go to ACCESS when the counter reaches 1.
- ACCESS (exactly one cycle):
  - Write: mem_wen=1, mem_waddr and mem_wdata from the captured registers.
  - Read: mem_ren=1, mem_raddr from the captured address.
  - In all other states mem_wen and mem_ren are 0, and the address/data outputs hold their last values.
  - Read data is captured from mem_rdata at the end of the ACCESS cycle. Writes capture 0.
  - Next state is RESP.
- RESP:
  - Granted requester's resp_valid=1 with rdata held stable until its resp_ready is high.
  - On that handshake: return to IDLE and clear grant.
  - No new request is accepted in the handshake cycle.
- Latency: request accepted at cycle T → memory access at T+LATENCY → resp_valid first high at T+LATENCY+1.
- Ordering: one outstanding transaction total; requests are never dropped or reordered per requester.
- Arbitration (default, fixed priority): LSU wins over IFU on simultaneous valid.
- Valid while not IDLE: req_ready stays 0; requesters hold valid and payload.
- resp_ready asserted without resp_valid: ignored.
- Address: forwarded unchanged (memory indexes with addr[7:0]). A write to index 0 is issued normally; the memory itself discards it.
- Reset mid-transaction: abort; pending response is lost. All outputs return to reset values the cycle after rst is sampled high.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-grant register resets to IFU, so the first tie goes to LSU.
  - On a tie, the requester not granted last wins.
  - Last-grant updates on each request handshake.
- Undefined: fixed LSU priority; no last-grant register exists.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum for the FSM states (IDLE, WAIT, ACCESS, RESP).
  - typedef enum for grant (GNT_NONE, GNT_IFU, GNT_LSU).
  - Constants XLEN=32 and MEM_IDX_W=8.
- Sub-module arb2: two-input arbiter (fixed/RR), combinational grant plus optional last-grant flop. Instantiated once.

Test Plan:
- Single IFU read, LATENCY=1: mem[4]=32'hDEADBEEF, ifu addr 4 accepted at T → mem_ren=1 with raddr=4 at T+1 → ifu_resp_valid at T+2, rdata=32'hDEADBEEF.
- LSU write then IFU read of the same address, LATENCY=3: LSU writes 32'h12345678 to addr 8 → mem_wen only at T+3, lsu_resp_valid at T+4, lsu_resp_rdata=0. IFU then reads addr 8 → 32'h12345678.
- Simultaneous requests, both valid for 4 transactions:
  - Fixed priority: grants LSU,LSU,LSU,LSU while LSU stays valid.
  - With MEM_ARB_RR_EN: grants LSU,IFU,LSU,IFU.
- Response backpressure: hold ifu_resp_ready=0 for 5 cycles → resp_valid and rdata stable, no mem_ren, lsu_req_ready=0 throughout; release → IDLE the next cycle.
- Reset mid-operation: rst high during WAIT with LATENCY=4 → next cycle resp_valid=0, mem_wen=mem_ren=0, FSM IDLE; the aborted write never reaches memory.
- Write to address 0: LSU writes 32'hFFFFFFFF to addr 0 → mem_wen=1 with waddr=0 issued; a subsequent read of addr 0 returns 0.
